// File: rtl/cmp_issue_ctrl.sv
// Issue controller for an external compare unit: one compare (single mode) or an
// eq/gt/lt sweep, with valid/ready handshakes on both request and response sides.
module cmp_issue_ctrl #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [width-1:0] req_a,
  input  logic [width-1:0] req_b,
  input  logic [1:0]       req_fun,
  input  logic             req_sweep,
  output logic [width-1:0] A,
  output logic [width-1:0] B,
  output logic [1:0]       alu_fun,
  output logic             cmp_EN,
  input  logic [width-1:0] cmp_out,
  input  logic             cmp_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [width-1:0] rsp_result,
  output logic             rsp_flag,
  output logic [2:0]       rsp_rel,
  output logic             rsp_err
);

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, ISSUE2, WAIT, RESP} state_t;

  localparam logic [1:0] FUN_EQ = 2'b01;
  localparam logic [1:0] FUN_GT = 2'b10;
  localparam logic [1:0] FUN_LT = 2'b11;

  state_t     state;
  logic [1:0] fun_q;
  logic       sweep_q;

  // Exactly one relation flag must be set for a consistent sweep.
  function automatic logic sweep_err(input logic [2:0] rel);
    return (rel != 3'b001) && (rel != 3'b010) && (rel != 3'b100);
  endfunction

  // Relation code; any inconsistent pattern (including none set) maps to 0.
  function automatic logic [width-1:0] rel_code(input logic [2:0] rel);
    logic [width-1:0] code;
    case (rel)
      3'b001:  code = width'(1);
      3'b010:  code = width'(2);
      3'b100:  code = width'(3);
      default: code = '0;
    endcase
    return code;
  endfunction

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    cmp_EN  = 1'b0;
    alu_fun = 2'b00;
    case (state)
      ISSUE0: begin
        cmp_EN  = 1'b1;
        alu_fun = sweep_q ? FUN_EQ : fun_q;
      end
      ISSUE1: begin
        cmp_EN  = 1'b1;
        alu_fun = FUN_GT;
      end
      ISSUE2: begin
        cmp_EN  = 1'b1;
        alu_fun = FUN_LT;
      end
      default: ;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rest) begin
      state      <= IDLE;
      A          <= '0;
      B          <= '0;
      fun_q      <= '0;
      sweep_q    <= 1'b0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
      rsp_rel    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            A        <= req_a;
            B        <= req_b;
            fun_q    <= req_fun;
            sweep_q  <= req_sweep;
            rsp_flag <= 1'b0;
            rsp_rel  <= '0;
            rsp_err  <= 1'b0;
            state    <= ISSUE0;
          end
        end
        ISSUE0: begin
          if (sweep_q) begin
            rsp_rel[0] <= cmp_flag;
            state      <= ISSUE1;
          end else begin
            rsp_flag <= cmp_flag;
            state    <= WAIT;
          end
        end
        ISSUE1: begin
          rsp_rel[1] <= cmp_flag;
          state      <= ISSUE2;
        end
        ISSUE2: begin
          rsp_rel[2] <= cmp_flag;
          state      <= WAIT;
        end
        WAIT: begin
          // cmp_out from the single issue is valid only during this cycle.
          if (sweep_q) begin
            rsp_result <= rel_code(rsp_rel);
            rsp_err    <= sweep_err(rsp_rel);
          end else begin
            rsp_result <= cmp_out;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cmp_issue_ctrl.md
CMP_ISSUE_CTRL -- requirements
Module: cmp_issue_ctrl

Interface
REQ-001 The block SHALL have parameter `width`, default 16, giving the operand and result width in bits.
REQ-002 `clk`  in  1  single clock; all state changes on its rising edge.
REQ-003 `rest`  in  1  reset, synchronous and active-high.
REQ-004 `req_valid`  in  1  request offered.
REQ-005 `req_ready`  out  1  block can accept a request.
REQ-006 `req_a`, `req_b`  in  width  operands.
REQ-007 `req_fun`  in  2  compare function for single mode.
REQ-008 `req_sweep`  in  1  selects sweep mode: 1 = sweep, 0 = single.
REQ-009 `A`, `B`  out  width  operands driven to the compare unit.
REQ-010 `alu_fun`  out  2  function driven to the compare unit.
REQ-011 `cmp_EN`  out  1  compare-unit enable.
REQ-012 `cmp_out`  in  width  registered compare result, valid one clock after its issue cycle.
REQ-013 `cmp_flag`  in  1  combinational compare flag, valid in the issue cycle.
REQ-014 `rsp_valid`  out  1  response available.
REQ-015 `rsp_ready`  in  1  consumer takes the response.
REQ-016 `rsp_result`  out  width  result value.
REQ-017 `rsp_flag`  out  1  flag of the single op.
REQ-018 `rsp_rel`  out  3  sweep flags {lt, gt, eq}.
REQ-019 `rsp_err`  out  1  sweep consistency error.

Function
REQ-020 The block SHALL implement the states IDLE, ISSUE0, ISSUE1, ISSUE2, WAIT and RESP.
REQ-021 `req_ready` SHALL be 1 only in IDLE; a request is accepted on an edge where `req_valid` and `req_ready` are both 1.
REQ-022 On acceptance, the block SHALL register `req_a`, `req_b`, `req_fun` and `req_sweep`, and `A`/`B` SHALL hold those operands until the next acceptance.
REQ-023 Single mode: the state sequence SHALL be IDLE -> ISSUE0 -> WAIT -> RESP.
  - In ISSUE0: `cmp_EN` = 1 and `alu_fun` = the registered `req_fun`.
REQ-024 Sweep mode: the state sequence SHALL be IDLE -> ISSUE0 -> ISSUE1 -> ISSUE2 -> WAIT -> RESP.
  - `alu_fun` SHALL be 01, 10, 11 in ISSUE0, ISSUE1, ISSUE2 respectively.
  - `cmp_EN` SHALL be 1 in each of these states.
REQ-025 Outside the ISSUEx states, `cmp_EN` SHALL be 0 and `alu_fun` SHALL be 00.
  - Both SHALL be decoded from registered state only, with no combinational path from request or response inputs.
REQ-026 `cmp_flag` SHALL be sampled at the end of each ISSUEx cycle.
  - Single mode: the sample goes to `rsp_flag`.
  - Sweep mode: ISSUE0 -> `rsp_rel[0]` (eq), ISSUE1 -> `rsp_rel[1]` (gt), ISSUE2 -> `rsp_rel[2]` (lt).
REQ-027 Single mode: `rsp_result` SHALL be `cmp_out` sampled at the end of WAIT; `rsp_rel` SHALL be 000 and `rsp_err` SHALL be 0.
REQ-028 Sweep mode: `rsp_result` SHALL be the relation code: 1 for eq, 2 for gt, 3 for lt, 0 if no flag was set.
  - `rsp_err` SHALL be 1 when the popcount of `rsp_rel` is not 1.
  - `rsp_err` = 1 SHALL force `rsp_result` to 0.
  - `rsp_flag` SHALL be 0.
REQ-029 `rsp_valid` SHALL be 1 only in RESP; all rsp_* outputs SHALL stay stable while `rsp_valid` = 1 and `rsp_ready` = 0.
REQ-030 RESP SHALL go to IDLE on the edge where `rsp_ready` = 1; no request is accepted in that same cycle.
REQ-031 Latency SHALL be fixed:
  - Accept edge k -> `rsp_valid` from cycle k+3 in single mode.
  - Accept edge k -> `rsp_valid` from cycle k+5 in sweep mode.
  - Earliest next acceptance SHALL be one cycle after the response handshake.
REQ-032 Operands are unsigned; the block SHALL perform no arithmetic on them.
REQ-033 `req_*` changes outside IDLE SHALL have no effect.

Reset
REQ-034 While `rest` = 1 at an edge, the block SHALL go to IDLE and set the following to 0: `A`, `B`, the registered function, `rsp_result`, `rsp_flag`, `rsp_rel`, `rsp_err`.
REQ-035 Consequently, from the cycle after a reset edge: `rsp_valid` = 0, `cmp_EN` = 0, `alu_fun` = 00, `req_ready` = 1.
REQ-036 Reset in any state, including mid-sweep or in RESP, SHALL discard the operation with no response produced.
REQ-037 A request offered in a cycle where `rest` = 1 SHALL NOT be accepted.

Verification
REQ-038 Single mode: A=5, B=5, fun=01, `rsp_ready` held 1 -> `cmp_EN` high for exactly one cycle; `rsp_valid` at k+3 with `rsp_result` = 1, `rsp_flag` = 1, `rsp_rel` = 000.
REQ-039 Sweep mode: A=9, B=3 -> `alu_fun` 01, 10, 11 on three consecutive cycles; response `rsp_rel` = 010, `rsp_result` = 2, `rsp_err` = 0. Repeat with A=2, B=7 -> `rsp_rel` = 100, `rsp_result` = 3.
REQ-040 Backpressure: `rsp_ready` = 0 for 4 cycles during RESP -> `rsp_valid` and outputs stable; `req_ready` = 0 throughout; IDLE one cycle after `rsp_ready` = 1.
REQ-041 Error injection: sweep where the compare model forces `cmp_flag` = 1 on all three issues -> `rsp_rel` = 111, `rsp_err` = 1, `rsp_result` = 0.
REQ-042 Reset in ISSUE1 of a sweep -> next cycle `cmp_EN` = 0, `req_ready` = 1; no `rsp_valid` ever appears for that request.
REQ-043 Single mode fun=00, A=0xFFFF, B=0 -> `rsp_result` = 0, `rsp_flag` = 1.
